jk_seq_driver: RTL and testbench

- Synthesizable stimulus/checker for one JK storage element. It is the driving end of the j/k/q interface.
- Generates j/k command sequences and the element's reset, then samples the returned q and compares it against an internal JK reference model.
- Reports pass/fail and an error count.
- Used for on-chip self-test of JK latch/flip-flop instances. Replaces free-running benches for those elements.

---
 rtl/jk_seq_driver.sv | 249 ++++++++++++++++++++++++
 tb/tb_jk_seq_driver.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_seq_driver.sv
// jk_seq_driver
// -------------
// On-chip self-test driver/checker for a single JK storage element.
// It issues the element's reset, then runs a fixed set / hold / clear /
// toggle command sequence NUM_PASSES times. After each command it waits
// SETTLE_CYCLES quiet cycles and then compares the returned q against an
// internal JK reference model.
//
// Parameters
//   NUM_PASSES    : repetitions of the 4-operation sequence per run (>=1)
//   SETTLE_CYCLES : j=k=0 cycles after each operation before q is sampled (>=1)
//   CNT_W         : width of the saturating mismatch counter
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-high reset
//   start     in   pulse; begins a run when not busy
//   q_in      in   q returned by the element under test
//   j, k      out  JK command to the element
//   dut_reset out  reset to the element under test
//   busy      out  run in progress
//   done      out  run complete, held until the next start
//   pass      out  valid with done; 1 iff no mismatches were seen
//   err_count out  mismatches in the current/last run, saturating
//   step      out  current operation index 0..3
//
// Every output is a flop. The combinational block computes the next
// state first and then decodes the next output values from that next
// state, so the registered outputs always match the current state.

module jk_seq_driver #(
   parameter int NUM_PASSES    = 2,
   parameter int SETTLE_CYCLES = 2,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             q_in,
   output logic             j,
   output logic             k,
   output logic             dut_reset,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CNT_W-1:0] err_count,
   output logic [1:0]       step
);

   localparam int PW = $clog2(NUM_PASSES + 1);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [PW-1:0] PASS_LAST   = PW'(NUM_PASSES);
   localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RST    = 3'd1,
      APPLY  = 3'd2,
      SETTLE = 3'd3,
      SAMPLE = 3'd4,
      DONE   = 3'd5
   } state_t;

   state_t           state;
   state_t           state_next;

   logic             exp_q;
   logic             exp_q_next;
   logic [PW-1:0]    pass_cnt;
   logic [PW-1:0]    pass_cnt_next;
   logic [PW-1:0]    pass_cnt_inc;
   logic [SW-1:0]    settle_cnt;
   logic [SW-1:0]    settle_cnt_next;

   logic             j_next;
   logic             k_next;
   logic             dut_reset_next;
   logic             busy_next;
   logic             done_next;
   logic             pass_next;
   logic [CNT_W-1:0] err_count_next;
   logic [1:0]       step_next;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Reference model, loop counters and registered outputs. During reset
   // the element under test is held in reset as well.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q      <= 1'b0;
         pass_cnt   <= '0;
         settle_cnt <= '0;
         j          <= 1'b0;
         k          <= 1'b0;
         dut_reset  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         step       <= 2'd0;
      end else begin
         exp_q      <= exp_q_next;
         pass_cnt   <= pass_cnt_next;
         settle_cnt <= settle_cnt_next;
         j          <= j_next;
         k          <= k_next;
         dut_reset  <= dut_reset_next;
         busy       <= busy_next;
         done       <= done_next;
         pass       <= pass_next;
         err_count  <= err_count_next;
         step       <= step_next;
      end
   end

   // Next-state logic plus reference-model and counter updates. The
   // output decode at the bottom uses only state_next and the *_next
   // values, so each output lines up with the state it belongs to.
   always_comb begin
      state_next      = state;
      exp_q_next      = exp_q;
      pass_cnt_next   = pass_cnt;
      pass_cnt_inc    = pass_cnt + 1'b1;
      settle_cnt_next = settle_cnt;
      err_count_next  = err_count;
      step_next       = step;
      j_next          = 1'b0;
      k_next          = 1'b0;
      dut_reset_next  = 1'b0;
      busy_next       = 1'b0;
      done_next       = 1'b0;
      pass_next       = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               state_next = RST;
            end
         end

         DONE: begin
            if (start) begin
               state_next = RST;
            end
         end

         RST: begin
            err_count_next = '0;
            pass_cnt_next  = '0;
            step_next      = 2'd0;
            exp_q_next     = 1'b0;
            state_next     = APPLY;
         end

         // The element sees j/k at the edge that ends this cycle, so the
         // model advances on that same edge.
         APPLY: begin
            case (step)
               2'd0:    exp_q_next = 1'b1;
               2'd1:    exp_q_next = exp_q;
               2'd2:    exp_q_next = 1'b0;
               default: exp_q_next = ~exp_q;
            endcase
            settle_cnt_next = SETTLE_LOAD;
            state_next      = SETTLE;
         end

         SETTLE: begin
            if (settle_cnt == '0) begin
               state_next = SAMPLE;
            end else begin
               settle_cnt_next = settle_cnt - 1'b1;
            end
         end

         // The compare result is saturating: once the counter is all-ones
         // it sticks, so a badly broken element never looks healthy again.
         SAMPLE: begin
            if ((q_in != exp_q) && (err_count != '1)) begin
               err_count_next = err_count + 1'b1;
            end
            step_next  = step + 2'd1;
            state_next = APPLY;
            if (step == 2'd3) begin
               pass_cnt_next = pass_cnt_inc;
               if (pass_cnt_inc == PASS_LAST) begin
                  state_next = DONE;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase

      // Output decode for the state being entered.
      case (state_next)
         RST: begin
            dut_reset_next = 1'b1;
            busy_next      = 1'b1;
         end

         APPLY: begin
            busy_next = 1'b1;
            case (step_next)
               2'd0: begin
                  j_next = 1'b1;
                  k_next = 1'b0;
               end
               2'd1: begin
                  j_next = 1'b0;
                  k_next = 1'b0;
               end
               2'd2: begin
                  j_next = 1'b0;
                  k_next = 1'b1;
               end
               default: begin
                  j_next = 1'b1;
                  k_next = 1'b1;
               end
            endcase
         end

         SETTLE, SAMPLE: begin
            busy_next = 1'b1;
         end

         DONE: begin
            done_next = 1'b1;
            pass_next = (err_count_next == '0);
         end

         default: begin
            busy_next = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_jk_seq_driver.sv
// tb_jk_seq_driver
// ----------------
// Directed bench for jk_seq_driver. The main instance uses default
// parameters. Its q_in comes from an ideal JK flip-flop model, or is tied
// low or tied high, depending on mode. A second instance with CNT_W=2 is
// fed the inverted model output so that its error counter saturates.

module tb_jk_seq_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       q_in;
   logic       j;
   logic       k;
   logic       dut_reset;
   logic       busy;
   logic       done;
   logic       pass;
   logic [7:0] err_count;
   logic [1:0] step;

   logic       start_sat;
   logic       q_in_sat;
   logic       j_sat;
   logic       k_sat;
   logic       dut_reset_sat;
   logic       busy_sat;
   logic       done_sat;
   logic       pass_sat;
   logic [1:0] err_sat;
   logic [1:0] step_sat;

   logic       q_model;
   logic       q_model_sat;
   logic [1:0] mode;

   int n_checks = 0;
   int n_fail   = 0;
   logic [1:0] jk_log [0:40];

   always #5 clk = ~clk;

   jk_seq_driver dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .q_in      (q_in),
      .j         (j),
      .k         (k),
      .dut_reset (dut_reset),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
      .err_count (err_count),
      .step      (step)
   );

   jk_seq_driver #(.NUM_PASSES(2), .SETTLE_CYCLES(2), .CNT_W(2)) dut_sat (
      .clk       (clk),
      .reset     (reset),
      .start     (start_sat),
      .q_in      (q_in_sat),
      .j         (j_sat),
      .k         (k_sat),
      .dut_reset (dut_reset_sat),
      .busy      (busy_sat),
      .done      (done_sat),
      .pass      (pass_sat),
      .err_count (err_sat),
      .step      (step_sat)
   );

   // Ideal JK flip-flops acting as the elements under test.
   always_ff @(posedge clk) begin
      if (dut_reset) q_model <= 1'b0;
      else begin
         case ({j, k})
            2'b10:   q_model <= 1'b1;
            2'b01:   q_model <= 1'b0;
            2'b11:   q_model <= ~q_model;
            default: q_model <= q_model;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (dut_reset_sat) q_model_sat <= 1'b0;
      else begin
         case ({j_sat, k_sat})
            2'b10:   q_model_sat <= 1'b1;
            2'b01:   q_model_sat <= 1'b0;
            2'b11:   q_model_sat <= ~q_model_sat;
            default: q_model_sat <= q_model_sat;
         endcase
      end
   end

   assign q_in     = (mode == 2'd0) ? q_model : ((mode == 2'd1) ? 1'b0 : 1'b1);
   assign q_in_sat = ~q_model_sat;

   // Pulses start from a negedge, then counts posedges until done shows up.
   // It logs j/k after each edge and optionally fires extra start pulses
   // mid-run. edges is 33 for a correctly timed default run.
   task automatic run_and_wait(input int glitch_a, input int glitch_b,
                               output int edges, output logic busy_n1,
                               output logic done_n1, output logic rst_n1);
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      busy_n1 = busy;
      done_n1 = done;
      rst_n1  = dut_reset;
      edges   = 0;
      while (!done && edges < 100) begin
         @(negedge clk);
         edges++;
         if (edges <= 40) jk_log[edges] = {j, k};
         start = (edges == glitch_a) || (edges == glitch_b);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      start_sat = 1'b0;
      mode = 2'd0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({j, k, dut_reset, busy, done, pass} !== 6'b001000) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got %b required 001000", {j, k, dut_reset, busy, done, pass});
      end
      n_checks++;
      if ({err_count, step} !== 10'd0) begin
         n_fail++;
         $display("[TB] FAIL reset_counts: got err=%0d step=%0d required 0/0", err_count, step);
      end
      // start asserted while reset is still high must be lost
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({busy, dut_reset, done} !== 3'b000) begin
         n_fail++;
         $display("[TB] FAIL start_with_reset: got busy/dut_reset/done=%b required 000", {busy, dut_reset, done});
      end
   endtask

   task automatic test_ideal();
      int e;
      logic b1, d1, r1;
      logic [1:0] exp_jk;
      mode = 2'd0;
      run_and_wait(-1, -1, e, b1, d1, r1);
      n_checks++;
      if ({b1, r1} !== 2'b11) begin
         n_fail++;
         $display("[TB] FAIL ideal_start: got busy/dut_reset=%b required 11", {b1, r1});
      end
      n_checks++;
      if (e != 33) begin
         n_fail++;
         $display("[TB] FAIL ideal_latency: got %0d cycles required 33", e);
      end
      n_checks++;
      if ({done, pass, busy, err_count} !== {3'b110, 8'd0}) begin
         n_fail++;
         $display("[TB] FAIL ideal_result: got done/pass/busy=%b err=%0d required 110 err=0", {done, pass, busy}, err_count);
      end
      for (int n = 1; n <= 32; n++) begin
         if ((n - 1) % 4 == 0) begin
            case (((n - 1) / 4) % 4)
               0:       exp_jk = 2'b10;
               1:       exp_jk = 2'b00;
               2:       exp_jk = 2'b01;
               default: exp_jk = 2'b11;
            endcase
         end else begin
            exp_jk = 2'b00;
         end
         n_checks++;
         if (jk_log[n] !== exp_jk) begin
            n_fail++;
            $display("[TB] FAIL jk_seq[%0d]: got %b required %b", n, jk_log[n], exp_jk);
         end
      end
   endtask

   task automatic test_tied(input logic [1:0] m, input logic [7:0] exp_err);
      int e;
      logic b1, d1, r1;
      mode = m;
      run_and_wait(-1, -1, e, b1, d1, r1);
      n_checks++;
      if (e != 33) begin
         n_fail++;
         $display("[TB] FAIL tied%0d_latency: got %0d required 33", m, e);
      end
      n_checks++;
      if ({done, pass} !== 2'b10 || err_count !== exp_err) begin
         n_fail++;
         $display("[TB] FAIL tied%0d_result: got done/pass=%b err=%0d required 10 err=%0d", m, {done, pass}, err_count, exp_err);
      end
   endtask

   task automatic test_back_to_back();
      int e;
      logic b1, d1, r1;
      mode = 2'd0;
      // starts from DONE with err_count still nonzero from the last run
      run_and_wait(3, 20, e, b1, d1, r1);
      n_checks++;
      if ({b1, d1} !== 2'b10) begin
         n_fail++;
         $display("[TB] FAIL b2b_restart: got busy/done=%b required 10", {b1, d1});
      end
      n_checks++;
      if (e != 33) begin
         n_fail++;
         $display("[TB] FAIL b2b_ignored_start: got %0d cycles required 33", e);
      end
      n_checks++;
      if ({done, pass} !== 2'b11 || err_count !== 8'd0) begin
         n_fail++;
         $display("[TB] FAIL b2b_result: got done/pass=%b err=%0d required 11 err=0", {done, pass}, err_count);
      end
   endtask

   task automatic test_saturate();
      int e;
      start_sat = 1'b1;
      @(negedge clk);
      start_sat = 1'b0;
      e = 0;
      while (!done_sat && e < 100) begin
         @(negedge clk);
         e++;
      end
      n_checks++;
      if (e != 33) begin
         n_fail++;
         $display("[TB] FAIL sat_latency: got %0d required 33", e);
      end
      n_checks++;
      if (err_sat !== 2'd3 || pass_sat !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL sat_count: got err=%0d pass=%b required err=3 pass=0", err_sat, pass_sat);
      end
   endtask

   task automatic test_reset_mid_run();
      int e;
      logic b1, d1, r1;
      mode = 2'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      // now in the first SETTLE cycle of step 2, pass 1
      n_checks++;
      if ({busy, step, j, k} !== {1'b1, 2'd2, 2'b00} || err_count !== 8'd2) begin
         n_fail++;
         $display("[TB] FAIL midrun_pre: got busy=%b step=%0d jk=%b err=%0d required 1/2/00/2", busy, step, {j, k}, err_count);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, j, k, dut_reset, done, pass} !== 6'b000100 || err_count !== 8'd0 || step !== 2'd0) begin
         n_fail++;
         $display("[TB] FAIL midrun_reset: got flags=%b err=%0d step=%0d required 000100/0/0", {busy, j, k, dut_reset, done, pass}, err_count, step);
      end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      mode = 2'd0;
      run_and_wait(-1, -1, e, b1, d1, r1);
      n_checks++;
      if (e != 33 || {done, pass} !== 2'b11 || err_count !== 8'd0) begin
         n_fail++;
         $display("[TB] FAIL midrun_rerun: got cycles=%0d done/pass=%b err=%0d required 33/11/0", e, {done, pass}, err_count);
      end
   endtask

   initial begin
      test_reset();
      test_ideal();
      test_tied(2'd1, 8'd6);
      test_tied(2'd2, 8'd2);
      test_back_to_back();
      test_saturate();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
